// File: rtl/pe_pkg.sv
// Types and defaults shared between the PE-array feeder and other array-side blocks.
package pe_pkg;

    localparam int PE_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/skew_lane.sv
// One row of the diagonal input skew: a DEPTH-stage shift register that only moves on step.
module skew_lane import pe_pkg::*; #(
    parameter int DEPTH = 1,
    parameter int DW    = PE_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] stage_reg [DEPTH];
    logic [DW-1:0] stage_in  [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_in[gi] = din;
            end else begin : g_tail
                assign stage_in[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) stage_reg[j] <= '0;
        end else if (step) begin
            for (int j = 0; j < DEPTH; j++) stage_reg[j] <= stage_in[j];
        end
    end

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/pe_array_feeder.sv
// Accepts A column vectors, skews them diagonally into the PE array and drains each tile with zeros.
module pe_array_feeder import pe_pkg::*; #(
    parameter int NUM1 = 16,
    parameter int DW   = PE_DW,
    parameter int KW   = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM1*DW-1:0] in_vec,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [NUM1*DW-1:0] A_left,
    output logic               EN,
    output logic               busy,
    output logic               done,
    output logic [KW-1:0]      beat_cnt
);

    localparam int FW         = (NUM1 > 2) ? $clog2(NUM1 - 1) : 1;
    localparam int FLUSH_LAST = (NUM1 > 1) ? NUM1 - 2 : 0;
    // A single-row array has nothing left to drain after its last beat.
    localparam feeder_state_t AFTER_LAST = (NUM1 > 1) ? FLUSH : DONE;

    feeder_state_t state_reg, state_next;
    logic [KW-1:0] beat_cnt_reg, beat_cnt_next;
    logic [FW-1:0] flush_cnt_reg, flush_cnt_next;
    logic          en_reg;
    logic          done_reg;
    logic          accept;
    logic          step;

    assign in_ready = (state_reg == IDLE) || (state_reg == STREAM);
    assign accept   = in_valid && in_ready;
    assign step     = accept || (state_reg == FLUSH);

    always_comb begin
        state_next     = state_reg;
        beat_cnt_next  = beat_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    beat_cnt_next  = KW'(1);
                    flush_cnt_next = '0;
                    state_next     = in_last ? AFTER_LAST : STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    beat_cnt_next = (beat_cnt_reg == '1) ? beat_cnt_reg : beat_cnt_reg + KW'(1);
                    if (in_last) state_next = AFTER_LAST;
                end
            end
            FLUSH: begin
                if (flush_cnt_reg == FW'(FLUSH_LAST)) begin
                    flush_cnt_next = '0;
                    state_next     = DONE;
                end else begin
                    flush_cnt_next = flush_cnt_reg + FW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg     <= IDLE;
            beat_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
            en_reg        <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            beat_cnt_reg  <= beat_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
            en_reg        <= step;
            // Pulse lands on the cycle after the final drained operand is presented.
            done_reg      <= (state_reg == DONE);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM1; gi++) begin : g_lane
            logic [DW-1:0] lane_in;
            assign lane_in = (state_reg == FLUSH) ? '0 : in_vec[gi*DW +: DW];

            skew_lane #(
                .DEPTH (gi + 1),
                .DW    (DW)
            ) u_skew_lane (
                .clk   (CLK),
                .rst_n (RESET),
                .step  (step),
                .din   (lane_in),
                .dout  (A_left[gi*DW +: DW])
            );
        end
    endgenerate

    assign EN       = en_reg;
    assign done     = done_reg;
    assign busy     = (state_reg != IDLE);
    assign beat_cnt = beat_cnt_reg;

endmodule

// File: tb/tb_pe_array_feeder.sv
// Randomised and directed bench for pe_array_feeder against a step-history reference model.
module tb_pe_array_feeder;

    localparam int NUM1 = 4;
    localparam int DW   = 32;
    localparam int KW   = 8;
    localparam int W    = NUM1 * DW;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  in_vec;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [W-1:0]  a_left;
    logic          en;
    logic          busy;
    logic          done;
    logic [KW-1:0] beat_cnt;

    int tests  = 0;
    int failed = 0;

    // Reference model: newest-first history of vectors shifted into the array.
    logic [W-1:0] hist[$];
    int           hold;       // cycles left with in_ready low after a last beat
    int           drain;      // zero-fill steps still owed to the array
    bit           new_tile;   // next accepted beat opens a tile
    int           exp_cnt;

    pe_array_feeder #(.NUM1(NUM1), .DW(DW), .KW(KW)) dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .in_vec   (in_vec),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .A_left   (a_left),
        .EN       (en),
        .busy     (busy),
        .done     (done),
        .beat_cnt (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pattern_vec(input int k);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM1; i++) v[i*DW +: DW] = DW'(k * 16 + i);
        return v;
    endfunction

    function automatic logic [W-1:0] random_vec();
        logic [W-1:0] v;
        for (int i = 0; i < NUM1; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    function automatic logic [W-1:0] expected_a_left();
        logic [W-1:0] e, h;
        e = '0;
        for (int i = 0; i < NUM1; i++) begin
            if (i < hist.size()) begin
                h = hist[i];
                e[i*DW +: DW] = h[i*DW +: DW];
            end
        end
        return e;
    endfunction

    task automatic model_clear();
        hist.delete();
        hold     = 0;
        drain    = 0;
        new_tile = 1'b1;
        exp_cnt  = 0;
    endtask

    // Drive one cycle of stimulus, advance the model and compare every output.
    task automatic cycle(input bit v, input bit l, input logic [W-1:0] vec);
        bit acc, fstep, stp;
        int had_hold;
        in_valid = v;
        in_last  = l;
        in_vec   = vec;
        #1;
        chk("in_ready", W'(in_ready), W'(hold == 0));
        acc      = v && (hold == 0);
        fstep    = (drain > 0);
        had_hold = hold;
        stp      = acc || fstep;
        @(posedge clk);
        #1;
        if (had_hold > 0) hold--;
        if (fstep) drain--;
        if (stp) begin
            hist.push_front(acc ? vec : '0);
            if (hist.size() > NUM1) void'(hist.pop_back());
        end
        if (acc) begin
            exp_cnt  = new_tile ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
            new_tile = l;
            if (l) begin
                hold  = NUM1;
                drain = NUM1 - 1;
            end
        end
        chk("A_left", a_left, expected_a_left());
        chk("EN", W'(en), W'(stp));
        chk("done", W'(done), W'(had_hold == 1));
        chk("busy", W'(busy), W'((hold > 0) || !new_tile));
        chk("beat_cnt", W'(beat_cnt), W'(exp_cnt));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, random_vec());
    endtask

    initial begin
        rst_n    = 1'b0;
        in_vec   = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_A_left", a_left, '0);
        chk("rst_EN", W'(en), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_beat_cnt", W'(beat_cnt), '0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));

        // Three-beat tile, continuous valid.
        for (int k = 0; k < 3; k++) cycle(1'b1, k == 2, pattern_vec(k));
        idle_cycles(8);
        chk("tile3_beat_cnt", W'(beat_cnt), W'(3));

        // Same tile with a two-cycle valid gap after the first beat.
        cycle(1'b1, 1'b0, pattern_vec(0));
        cycle(1'b0, 1'b0, random_vec());
        cycle(1'b0, 1'b0, random_vec());
        cycle(1'b1, 1'b0, pattern_vec(1));
        cycle(1'b1, 1'b1, pattern_vec(2));
        idle_cycles(8);

        // Single last beat straight from idle.
        cycle(1'b1, 1'b1, random_vec());
        idle_cycles(7);
        chk("single_beat_cnt", W'(beat_cnt), W'(1));

        // Valid held high through the drain; following beats must wait for ready.
        cycle(1'b1, 1'b0, random_vec());
        cycle(1'b1, 1'b1, random_vec());
        for (int i = 0; i < 10; i++) cycle(1'b1, i == 9, random_vec());
        idle_cycles(8);

        // Asynchronous reset in the middle of the drain.
        cycle(1'b1, 1'b1, random_vec());
        cycle(1'b0, 1'b0, random_vec());
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_A_left", a_left, '0);
        chk("midrst_EN", W'(en), '0);
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_beat_cnt", W'(beat_cnt), '0);
        model_clear();
        @(posedge clk);
        #1;
        chk("midrst_done", W'(done), '0);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", W'(in_ready), W'(1));
        idle_cycles(6);

        // Long tile: the beat counter saturates while data keeps flowing.
        for (int k = 0; k < 300; k++) cycle(1'b1, k == 299, random_vec());
        chk("sat_beat_cnt", W'(beat_cnt), W'(255));
        idle_cycles(6);

        // Random traffic with gaps and short tiles.
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), random_vec());
        idle_cycles(8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests %0d", tests);
        $fatal(1, "timeout");
    end

endmodule
